// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-memory bus and decoder-side signals of the fetch unit.
//
// Handshakes:
//   - ImemReq is a one-cycle pulse carrying ImemAddr. Memory always accepts it.
//     Exactly one ImemValid/ImemRdata beat returns, at least one cycle later.
//     At most one request is outstanding.
//   - The fetch unit asserts InstrValid while it holds a live instruction.
//     The decoder consumes it in any cycle with InstrValid=1 and Stall=0.
//     PcSrc/PcTarget are sampled only in that consume cycle.
interface instr_fetch_if;
    logic        Stall;
    logic        PcSrc;
    logic [31:0] PcTarget;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemValid;
    logic [31:0] ImemRdata;
    logic [31:0] Instr;
    logic [6:0]  Op;
    logic        InstrValid;
    logic [31:0] Pc;
    logic [31:0] PcPlus4;

    // Fetch unit side.
    modport master (
        input  Stall, PcSrc, PcTarget, ImemValid, ImemRdata,
        output ImemReq, ImemAddr, Instr, Op, InstrValid, Pc, PcPlus4
    );

    // Instruction memory / decoder side.
    modport slave (
        output Stall, PcSrc, PcTarget, ImemValid, ImemRdata,
        input  ImemReq, ImemAddr, Instr, Op, InstrValid, Pc, PcPlus4
    );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: PC owner and single-outstanding instruction fetch for the
// single-issue RISC-V core. Holds the fetched word for the decoder and applies
// the branch redirect when the decoder consumes the instruction.
// Optional: define FETCH_PERF_EN to add the FetchCount/StallCycles counters.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus,
    output logic [1:0]    dbg_state
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]   FetchCount,
    output logic [31:0]   StallCycles
`endif
);

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus4;
    logic        consume;
    logic        unused_target_lsbs;

    assign pc_plus4 = pc_q + 32'd4;
    assign consume  = (state_q == HOLD) && !bus.Stall;

    // Branch targets are word aligned; the low two bits are dropped.
    assign unused_target_lsbs = ^bus.PcTarget[1:0];

    // State, PC and held instruction registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ISSUE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Next-state logic: issue, wait for the single response, hold until consumed.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        unique case (state_q)
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.ImemValid) begin
                    instr_d = bus.ImemRdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (consume) begin
                    pc_d    = bus.PcSrc ? {bus.PcTarget[31:2], 2'b00} : pc_plus4;
                    state_d = ISSUE;
                end
            end
            default: begin
                state_d = ISSUE;
            end
        endcase
    end

    assign bus.ImemReq    = (state_q == ISSUE) && !rst;
    assign bus.ImemAddr   = pc_q;
    assign bus.Instr      = instr_q;
    assign bus.Op         = instr_q[6:0];
    assign bus.InstrValid = (state_q == HOLD);
    assign bus.Pc         = pc_q;
    assign bus.PcPlus4    = pc_plus4;
    assign dbg_state      = state_q;

`ifdef FETCH_PERF_EN
    // Performance counters: consumed instructions and stalled HOLD cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            FetchCount  <= '0;
            StallCycles <= '0;
        end else begin
            if (consume) begin
                FetchCount <= FetchCount + 32'd1;
            end
            if ((state_q == HOLD) && bus.Stall) begin
                StallCycles <= StallCycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized fetch sequences against a transaction-level model
// of the fetch unit; a per-cycle compare process checks every DUT output.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    // Expected entry: {full, req, addr, valid, instr, pc, fetch_count, stall_cycles}
    localparam int EW = 163;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_if bus ();
    logic [1:0] dbg_state;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_cycles;
`endif

    instr_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
`ifdef FETCH_PERF_EN
        ,
        .FetchCount  (fetch_count),
        .StallCycles (stall_cycles)
`endif
    );

    // ---------------- model state and scoreboard ----------------
    logic [31:0]   m_pc;
    logic [31:0]   m_instr;
    logic [31:0]   m_fc;
    logic [31:0]   m_sc;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] cmp_e;
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic rnd1();
        return 1'($urandom_range(0, 1));
    endfunction

    // ---------------- driver ----------------
    // One cycle: apply inputs just after the edge and record what the outputs
    // must show during this cycle (model state before this cycle's update).
    task automatic drive(input logic r, input logic st, input logic src, input logic [31:0] tgt,
                         input logic iv, input logic [31:0] rd,
                         input logic full, input logic req, input logic vld);
        @(posedge clk);
        #1;
        rst           = r;
        bus.Stall     = st;
        bus.PcSrc     = src;
        bus.PcTarget  = tgt;
        bus.ImemValid = iv;
        bus.ImemRdata = rd;
        exp_q.push_back({full, req, m_pc, vld, m_instr, m_pc, m_fc, m_sc});
    endtask

    task automatic do_reset(input int n);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        m_pc    = RESET_PC;
        m_instr = 32'h0;
        m_fc    = 32'h0;
        m_sc    = 32'h0;
        for (int i = 1; i < n; i++) begin
            drive(1'b1, rnd1(), rnd1(), $urandom, 1'b0, $urandom, 1'b1, 1'b0, 1'b0);
        end
    endtask

    // One instruction: request, 'lat' cycles until the response, 'stalls'
    // stalled HOLD cycles, then the consume. 'spur' pulses ImemValid with junk
    // in the request and HOLD cycles. 'abort' stops before that cycle index.
    task automatic do_fetch(input int lat, input int stalls, input logic src,
                            input logic [31:0] tgt, input logic [31:0] data,
                            input logic spur, input int abort,
                            input logic lit_en, input logic [31:0] lit_addr,
                            output logic aborted);
        int cyc;
        cyc     = 0;
        aborted = 1'b1;
        if (cyc == abort) return;
        drive(1'b0, rnd1(), rnd1(), $urandom, spur, $urandom, 1'b1, 1'b1, 1'b0);
        if (lit_en) begin
            #1;
            chk("lit_issue_addr", bus.ImemAddr, lit_addr);
        end
        cyc++;
        for (int k = 1; k <= lat; k++) begin
            if (cyc == abort) return;
            drive(1'b0, rnd1(), rnd1(), $urandom, (k == lat),
                  (k == lat) ? data : $urandom, 1'b1, 1'b0, 1'b0);
            cyc++;
        end
        m_instr = data;
        for (int s = 0; s < stalls; s++) begin
            if (cyc == abort) return;
            drive(1'b0, 1'b1, ($urandom_range(0, 3) != 0), $urandom, spur, $urandom,
                  1'b1, 1'b0, 1'b1);
            m_sc = m_sc + 32'd1;
            cyc++;
        end
        if (cyc == abort) return;
        drive(1'b0, 1'b0, src, tgt, spur, $urandom, 1'b1, 1'b0, 1'b1);
        m_fc    = m_fc + 32'd1;
        m_pc    = src ? {tgt[31:2], 2'b00} : m_pc + 32'd4;
        aborted = 1'b0;
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            cmp_e = exp_q.pop_front();
            chk("ImemReq", 32'(bus.ImemReq), 32'(cmp_e[161]));
            if (cmp_e[162]) begin
                chk("ImemAddr", bus.ImemAddr, cmp_e[160:129]);
                chk("InstrValid", 32'(bus.InstrValid), 32'(cmp_e[128]));
                chk("Instr", bus.Instr, cmp_e[127:96]);
                chk("Op", 32'(bus.Op), 32'(cmp_e[102:96]));
                chk("Pc", bus.Pc, cmp_e[95:64]);
                chk("PcPlus4", bus.PcPlus4, cmp_e[95:64] + 32'd4);
`ifdef FETCH_PERF_EN
                chk("FetchCount", fetch_count, cmp_e[63:32]);
                chk("StallCycles", stall_cycles, cmp_e[31:0]);
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic ab;
        int   perf_stalls[10];
        int   ab_at;
        perf_stalls = '{1, 0, 2, 0, 0, 1, 0, 3, 0, 0};

        bus.Stall     = 1'b0;
        bus.PcSrc     = 1'b0;
        bus.PcTarget  = 32'h0;
        bus.ImemValid = 1'b0;
        bus.ImemRdata = 32'h0;
        m_pc    = RESET_PC;
        m_instr = 32'h0;
        m_fc    = 32'h0;
        m_sc    = 32'h0;

        // Reset and first request.
        do_reset(3);
        #1;
        chk("lit_reset_pc", bus.Pc, 32'h100);
        chk("lit_reset_valid", 32'(bus.InstrValid), 32'h0);
        chk("lit_reset_req", 32'(bus.ImemReq), 32'h0);

        // Sequential fetch with a 1-cycle memory.
        do_fetch(1, 0, 1'b0, $urandom, 32'h00500093, 1'b0, -1, 1'b1, 32'h100, ab);
        #1;
        chk("lit_op1", 32'(bus.Op), 32'h13);
        chk("lit_pc1", bus.Pc, 32'h100);
        chk("lit_valid1", 32'(bus.InstrValid), 32'h1);
        do_fetch(1, 0, 1'b0, $urandom, 32'h00A00113, 1'b0, -1, 1'b1, 32'h104, ab);
        #1;
        chk("lit_instr2", bus.Instr, 32'h00A00113);
        chk("lit_pc2", bus.Pc, 32'h104);

        // Variable latency with spurious ImemValid in ISSUE and HOLD.
        do_fetch(4, 0, 1'b0, $urandom, 32'h12345637, 1'b1, -1, 1'b1, 32'h108, ab);
        #1;
        chk("lit_instr3", bus.Instr, 32'h12345637);

        // Five stall cycles, PcSrc mostly high while stalled, released with PcSrc=0.
        do_fetch(1, 5, 1'b0, $urandom, 32'h00000013, 1'b1, -1, 1'b1, 32'h10C, ab);
        // Redirect with misaligned target, then wrap at the top of memory.
        do_fetch(2, 0, 1'b1, 32'h0000_0203, 32'h00108093, 1'b0, -1, 1'b1, 32'h110, ab);
        do_fetch(1, 0, 1'b1, 32'hFFFF_FFFC, 32'h00210113, 1'b0, -1, 1'b1, 32'h200, ab);
        do_fetch(1, 0, 1'b0, $urandom, 32'h00318193, 1'b0, -1, 1'b1, 32'hFFFF_FFFC, ab);
        do_fetch(1, 0, 1'b0, $urandom, 32'h00420213, 1'b0, -1, 1'b1, 32'h0, ab);

        // Ten consumes carrying seven stall cycles in total.
        do_reset(2);
        for (int i = 0; i < 10; i++) begin
            do_fetch(1, perf_stalls[i], 1'b0, $urandom, $urandom, 1'b0, -1, 1'b0, 32'h0, ab);
        end
        do_fetch(1, 0, 1'b0, $urandom, $urandom, 1'b0, 1, 1'b1, 32'h128, ab);
`ifdef FETCH_PERF_EN
        #1;
        chk("lit_fetch_count", fetch_count, 32'd10);
        chk("lit_stall_cycles", stall_cycles, 32'd7);
`endif
        do_reset(2);
`ifdef FETCH_PERF_EN
        #1;
        chk("lit_fetch_count_rst", fetch_count, 32'd0);
        chk("lit_stall_cycles_rst", stall_cycles, 32'd0);
`endif

        // Randomized traffic with occasional mid-operation resets.
        for (int n = 0; n < 300; n++) begin
            ab_at = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 9)) : -1;
            do_fetch(int'($urandom_range(1, 6)), int'($urandom_range(0, 4)), rnd1(),
                     $urandom, $urandom, rnd1(), ab_at, 1'b0, 32'h0, ab);
            if (ab) begin
                do_reset(int'($urandom_range(2, 3)));
            end
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the single-issue RISC-V core.
- Owns the program counter and issues one read at a time to instruction memory.
- Holds the returned word and presents it, with its opcode field, to the main decoder.
- Applies the decoder's PcSrc/branch-target redirect when the decoder consumes the instruction.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded by reset; bits [1:0] must be 0.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- Stall  in  1  decode not ready; holds the current instruction.
- PcSrc  in  1  take branch for the instruction being consumed.
- PcTarget  in  32  branch target; bits [1:0] ignored (treated as 00).
- ImemReq  out  1  read request, one-cycle pulse.
- ImemAddr  out  32  read address, equal to Pc.
- ImemValid  in  1  read data valid; arrives at least 1 cycle after ImemReq.
- ImemRdata  in  32  read data.
- Instr  out  32  held instruction word.
- Op  out  7  Instr[6:0], drives the decoder op input.
- InstrValid  out  1  Instr/Op/Pc describe a live instruction.
- Pc  out  32  address of the current instruction.
- PcPlus4  out  32  Pc + 4, modulo 2^32.

## Operation
- FSM states and transitions:
  - ISSUE: ImemReq=1, ImemAddr=Pc; always moves to WAIT next cycle. Memory always accepts the request.
  - WAIT: on ImemValid, Instr<=ImemRdata and the FSM moves to HOLD; otherwise it stays in WAIT.
  - HOLD: InstrValid=1. When Stall=0 the instruction is consumed: Pc<=PcSrc ? {PcTarget[31:2],2'b00} : PcPlus4, and the FSM moves to ISSUE. When Stall=1, Instr, Pc and state are unchanged.
- Outstanding requests: at most one.
- ImemValid outside WAIT is ignored. Instr is unchanged.
- PcSrc and PcTarget are sampled only on the consume cycle (HOLD && !Stall). They are don't-care otherwise.
- Arithmetic: all PC arithmetic is 32-bit unsigned and wraps, so 32'hFFFF_FFFC + 4 = 32'h0.
- Simultaneous events: ImemValid in HOLD is ignored. PcSrc with Stall=1 has no effect.
- Reset mid-operation:
  - FSM returns to ISSUE, Pc=RESET_PC and InstrValid=0.
  - Instruction memory is reset by the same rst and discards any pending response; a stale ImemValid is not possible by contract.

## Timing
- Reset values: Pc=RESET_PC, PcPlus4=RESET_PC+4, Instr=0, Op=0, InstrValid=0.
- ImemReq is 0 while rst=1.
- First request: ImemReq=1 in the first cycle after rst deasserts.
- Latency: ImemValid in cycle N gives InstrValid=1 in cycle N+1.
- Best-case throughput is 3 cycles per instruction: ISSUE, WAIT with a 1-cycle memory, then HOLD with Stall=0.
- InstrValid falls the cycle after consume. The next ImemReq occurs in that same cycle with ImemAddr equal to the new Pc.
- Op, PcPlus4 and ImemAddr are combinational from registered state.
- ImemReq is combinational from state and rst.

## Configuration
- FETCH_PERF_EN defined:
  - Adds outputs FetchCount [31:0] and StallCycles [31:0], both reset to 0 and wrapping at 2^32.
  - FetchCount increments on each consume.
  - StallCycles increments on each cycle in HOLD with Stall=1.
- FETCH_PERF_EN undefined:
  - The ports and counters do not exist. All other behaviour is identical.

## Test plan
- Reset: hold rst for 3 cycles with RESET_PC=32'h100 -> Pc=32'h100, InstrValid=0 and ImemReq=0 during rst; ImemReq=1 with ImemAddr=32'h100 in the first cycle after release.
- Sequential fetch: memory with 1-cycle latency returning 32'h00500093 then 32'h00A00113, Stall=0 -> Op=7'b0010011 and InstrValid=1 three cycles apart; Pc goes 32'h100 then 32'h104.
- Variable latency: ImemValid 4 cycles after ImemReq; spurious ImemValid pulses in ISSUE and HOLD -> stays in WAIT until the real pulse; Instr is unaffected by the spurious pulses.
- Stall: Stall=1 for 5 cycles in HOLD, PcSrc=1 during the stall -> Instr/Pc held and no ImemReq; on release with PcSrc=0, next ImemAddr=Pc+4.
- Redirect and wrap:
  - Consume with PcSrc=1, PcTarget=32'h0000_0203 -> next ImemAddr=32'h0000_0200.
  - Pc=32'hFFFF_FFFC, PcSrc=0 -> next Pc=32'h0.
- Perf (FETCH_PERF_EN): 10 consumes with 7 total stall cycles -> FetchCount=10, StallCycles=7; rst mid-run -> both return to 0.
